// File: rtl/fetch_ctrl_pkg.sv
// Shared defaults and FSM encoding for the instruction-fetch controller.
package fetch_ctrl_pkg;
  localparam int          WIDTH_DEF    = 32;
  localparam int          IMEM_LEN_DEF = 72;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue; entry 0 is always the head.
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  output logic [WIDTH-1:0] head_pc,
  output logic [WIDTH-1:0] head_instr,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] pc0, pc1, ins0, ins1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc0   <= '0;
      pc1   <= '0;
      ins0  <= '0;
      ins1  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            pc0  <= in_pc;
            ins0 <= in_instr;
          end else begin
            pc1  <= in_pc;
            ins1 <= in_instr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0   <= pc1;
          ins0  <= ins1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever stays queued.
          if (count == 2'd1) begin
            pc0  <= in_pc;
            ins0 <= in_instr;
          end else begin
            pc0  <= pc1;
            ins0 <= ins1;
            pc1  <= in_pc;
            ins1 <= in_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_pc    = pc0;
  assign head_instr = ins0;
endmodule

// File: rtl/fetch_ctrl.sv
// Sequential instruction fetch with redirect, bounds fault and a 2-deep output queue.
// Handshake: a word transfers on any rising edge where out_valid && out_ready are both 1.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter int               IMEM_LEN = IMEM_LEN_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-3:0] imem_add,
  input  logic [WIDTH-1:0] imem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             fault,
  output logic [WIDTH-1:0] fault_pc,
  output state_t           fsm_state
);
  state_t           state, state_d;
  logic [WIDTH-1:0] pc, pc_d, fault_pc_d;
  logic             push, pop, flush, in_range;
  logic [1:0]       count;
  logic [WIDTH:0]   pc_end;

  // One extra bit so the bounds check sees the carry instead of a wrapped pc.
  assign pc_end   = {1'b0, pc} + (WIDTH+1)'(4);
  assign in_range = pc_end <= (WIDTH+1)'(IMEM_LEN);

  assign imem_add  = pc[WIDTH-1:2];
  assign out_valid = (count != 2'd0) && (state == ST_FETCH);
  assign fault     = (state == ST_FAULT);
  assign fsm_state = state;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    fault_pc_d = fault_pc;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = ST_FAULT;
        fault_pc_d = redirect_pc;
      end else begin
        state_d    = ST_FETCH;
        pc_d       = redirect_pc;
        fault_pc_d = '0;
      end
    end else if (state == ST_FETCH) begin
      pop = out_valid && out_ready;
      if ((count < 2'd2) || pop) begin
        if (in_range) begin
          push = 1'b1;
          pc_d = pc + WIDTH'(4);
        end else if (count == 2'd0) begin
          // Out of range: let queued words drain before halting.
          state_d    = ST_FAULT;
          fault_pc_d = pc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      fault_pc <= fault_pc_d;
    end
  end

  fetch_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .in_pc      (pc),
    .in_instr   (imem_data),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (count)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized checks of fetch_ctrl against a queue-based fetch model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int W   = 32;
  localparam int LEN = 72;
  localparam int NW  = LEN / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-3:0] imem_add;
  logic [W-1:0] imem_data;
  logic         out_valid, out_ready;
  logic [W-1:0] out_instr, out_pc;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         fault;
  logic [W-1:0] fault_pc;
  state_t       fsm_state;

  logic [W-1:0] mem [NW];
  int           total = 0;
  int           bad   = 0;

  // Reference model: queue of fetched addresses, next fetch address, fault status.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_pc;
  logic         m_fault;
  logic [W-1:0] m_fault_pc;
  logic [W-1:0] last_seen;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_add       (imem_add),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fsm_state      (fsm_state)
  );

  function automatic logic [W-1:0] mem_word(input logic [W-3:0] a);
    if (int'(a) < NW) return mem[int'(a)];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_data = mem_word(imem_add);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc       = 0;
    m_fault    = 1'b0;
    m_fault_pc = 0;
  endtask

  task automatic check_model();
    logic ev;
    ev = !m_fault && (exp_q.size() != 0);
    chk("out_valid", W'(out_valid), W'(ev));
    chk("fault", W'(fault), W'(m_fault));
    chk("fsm_state", W'(fsm_state), m_fault ? W'(ST_FAULT) : W'(ST_FETCH));
    if (!m_fault) chk("imem_add", W'(imem_add), m_pc >> 2);
    if (ev) begin
      chk("out_pc", out_pc, exp_q[0]);
      chk("out_instr", out_instr, mem_word(exp_q[0][W-1:2]));
    end
    if (m_fault) chk("fault_pc", fault_pc, m_fault_pc);
  endtask

  // Called just after a falling edge: check, drive, advance one clock, update model.
  task automatic step(input logic rdy, input logic rv, input logic [W-1:0] rpc);
    int n;
    bit popped;
    check_model();
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    if (rv) begin
      exp_q.delete();
      if (rpc[1:0] != 2'b00) begin
        m_fault    = 1'b1;
        m_fault_pc = rpc;
      end else begin
        m_fault = 1'b0;
        m_pc    = rpc;
      end
    end else if (!m_fault) begin
      n      = exp_q.size();
      popped = rdy && (n != 0);
      if (popped) void'(exp_q.pop_front());
      if (n < 2 || popped) begin
        if (longint'(m_pc) + 4 <= longint'(LEN)) begin
          exp_q.push_back(m_pc);
          m_pc = m_pc + 4;
        end else if (n == 0) begin
          m_fault    = 1'b1;
          m_fault_pc = m_pc;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rpc;
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);

    chk("rst_valid", W'(out_valid), 0);
    chk("rst_fault", W'(fault), 0);
    chk("rst_fault_pc", fault_pc, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_imem_add", W'(imem_add), 0);

    rst = 1'b0;
    model_reset();

    // Streaming at full rate from the reset address.
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, '0);
      chk("seq_valid", W'(out_valid), 1);
      chk("seq_pc", out_pc, W'(4 * (k - 1)));
      chk("seq_instr", out_instr, mem[k-1]);
    end

    // Backpressure: queue fills, then drains in order without gaps.
    step(1'b1, 1'b1, '0);
    repeat (5) step(1'b0, 1'b0, '0);
    chk("hold_pc", out_pc, 0);
    chk("hold_add", W'(imem_add), 2);
    chk("hold_valid", W'(out_valid), 1);
    step(1'b1, 1'b0, '0);
    chk("drain_pc4", out_pc, 4);
    chk("drain_valid4", W'(out_valid), 1);
    step(1'b1, 1'b0, '0);
    chk("drain_pc8", out_pc, 8);

    // Redirect while full.
    step(1'b1, 1'b1, 32'h20);
    chk("redir_bubble", W'(out_valid), 0);
    step(1'b1, 1'b0, '0);
    chk("redir_valid", W'(out_valid), 1);
    chk("redir_pc", out_pc, 32'h20);

    // Misaligned redirect faults; aligned redirect recovers.
    step(1'b0, 1'b1, 32'h22);
    chk("mis_fault", W'(fault), 1);
    chk("mis_fault_pc", fault_pc, 32'h22);
    chk("mis_valid", W'(out_valid), 0);
    step(1'b1, 1'b0, '0);
    chk("mis_hold", W'(fault), 1);
    step(1'b0, 1'b1, 32'h10);
    chk("rec_fault", W'(fault), 0);
    chk("rec_bubble", W'(out_valid), 0);
    step(1'b1, 1'b0, '0);
    chk("rec_valid", W'(out_valid), 1);
    chk("rec_pc", out_pc, 32'h10);

    // Run off the end of instruction memory.
    step(1'b1, 1'b1, 32'h38);
    last_seen = '0;
    for (int i = 0; i < 30 && !fault; i++) begin
      if (out_valid) last_seen = out_pc;
      step(1'b1, 1'b0, '0);
    end
    chk("end_last_pc", last_seen, 32'h44);
    chk("end_fault", W'(fault), 1);
    chk("end_fault_pc", fault_pc, 32'h48);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       rpc = 32'hFFFF_FFFC;
        1:       rpc = W'($urandom_range(0, NW) * 4 + $urandom_range(1, 3));
        default: rpc = W'($urandom_range(0, NW) * 4);
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rpc);
    end

    // Reset mid-stream with a full queue and a redirect pending.
    step(1'b1, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("mid_valid", W'(out_valid), 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_add", W'(imem_add), 0);
    model_reset();
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, '0);
    chk("restart_valid", W'(out_valid), 1);
    chk("restart_pc", out_pc, 0);
    repeat (4) step(1'b1, 1'b0, '0);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
